// File: rtl/div_seq.sv
// rtl/div_seq.sv - multi-cycle radix-2 restoring 32-bit divider (DIV/DIVU)
//
// Purpose:
//   Executes DIV (signed) and DIVU (unsigned) for the execute stage, one
//   quotient bit per cycle. Produces {remainder, quotient} for HI/LO and
//   holds the pipeline via stall_o while an operation is in flight.
//
// Ports:
//   clk           in   1  rising-edge clock
//   rst           in   1  synchronous active-high reset
//   signed_div_i  in   1  1 = DIV (signed), 0 = DIVU; sampled on accept
//   opdata1_i     in  32  dividend; sampled on accept
//   opdata2_i     in  32  divisor; sampled on accept
//   start_i       in   1  request, held high until ready_o is seen
//   annul_i       in   1  abort request (flush / exception)
//   result_o      out 64  {remainder, quotient}; zero outside END
//   ready_o       out  1  high only in END
//   stall_o       out  1  start_i & ~ready_o (combinational)

module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stall_o
);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  // Operation context captured when a divide is accepted.
  logic        sgn;        // signed operation
  logic        dvd_neg;    // dividend sign bit
  logic        dvs_neg;    // divisor sign bit
  logic [31:0] dvs_mag;    // |divisor| (raw value when unsigned)

  // Work register: [64:32] partial remainder, [31:0] dividend bits being
  // shifted out while quotient bits are shifted in from the bottom.
  logic [64:0] work;
  logic [5:0]  cnt;

  // Control strobes from the output process.
  logic        load_ops;
  logic        step;
  logic [63:0] result_nxt;
  logic        ready_nxt;

  // Request decode.
  logic accept;
  logic abort;
  logic last_iter;

  assign accept    = start_i & ~annul_i;
  assign abort     = annul_i | ~start_i;
  assign last_iter = (cnt == 6'd31);

  // --------------------------------------------------------------------
  // Operand magnitudes at accept time.
  // --------------------------------------------------------------------
  logic [31:0] dvd_abs;
  logic [31:0] dvs_abs;

  // Negating 0x80000000 yields 0x80000000, which is the correct unsigned
  // magnitude 2^31, so no special case is needed for the most negative value.
  assign dvd_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign dvs_abs = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  // --------------------------------------------------------------------
  // One restoring iteration.
  // --------------------------------------------------------------------
  logic [65:0] work_shift;
  logic [33:0] trial;
  logic [64:0] work_step;

  // The shift is taken one bit wider than the work register so that the
  // subtraction sees every bit of the partial remainder; the borrow out of
  // the 34-bit difference is the "trial went negative" flag.
  assign work_shift = {work, 1'b0};
  assign trial      = work_shift[65:32] - {2'b00, dvs_mag};

  always_comb begin
    work_step = work_shift[64:0];
    if (!trial[33]) begin
      work_step = {trial[32:0], work_shift[31:1], 1'b1};
    end
  end

  // --------------------------------------------------------------------
  // Sign fixup applied to the value produced by the final iteration.
  // --------------------------------------------------------------------
  logic [31:0] quot_raw;
  logic [31:0] rem_raw;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;
  logic        unused_work_msb;

  assign quot_raw = work_step[31:0];
  assign rem_raw  = work_step[63:32];

  // The remainder is always smaller than the divisor, so bit 64 is zero
  // after every completed iteration and carries no result information.
  assign unused_work_msb = work_step[64];

  // Quotient sign follows the XOR of operand signs; remainder sign follows
  // the dividend (truncating division).
  assign quot_fix = (sgn && (dvd_neg ^ dvs_neg)) ? (~quot_raw + 32'd1) : quot_raw;
  assign rem_fix  = (sgn && dvd_neg)             ? (~rem_raw + 32'd1)  : rem_raw;

  // --------------------------------------------------------------------
  // FSM: state register.
  // --------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FREE;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------
  // FSM: next-state logic.
  // --------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      S_FREE: begin
        // annul_i masks a simultaneous start, so nothing is launched.
        if (accept) begin
          next_state = (opdata2_i == 32'd0) ? S_BYZERO : S_ON;
        end
      end
      S_BYZERO: begin
        next_state = S_END;
      end
      S_ON: begin
        // Abort has priority even over the final iteration.
        if (abort) begin
          next_state = S_FREE;
        end else if (last_iter) begin
          next_state = S_END;
        end
      end
      S_END: begin
        // annul_i is deliberately not looked at here: the result is
        // already architecturally complete.
        if (!start_i) begin
          next_state = S_FREE;
        end
      end
      default: begin
        next_state = S_FREE;
      end
    endcase
  end

  // --------------------------------------------------------------------
  // FSM: output / control decode.
  // --------------------------------------------------------------------
  always_comb begin
    load_ops   = 1'b0;
    step       = 1'b0;
    result_nxt = 64'd0;
    ready_nxt  = (next_state == S_END);

    case (state)
      S_FREE: begin
        load_ops = (next_state == S_ON);
      end
      S_BYZERO: begin
        // Divide-by-zero result is fixed to zero.
        result_nxt = 64'd0;
      end
      S_ON: begin
        step = ~abort;
        if (next_state == S_END) begin
          result_nxt = {rem_fix, quot_fix};
        end
      end
      S_END: begin
        if (next_state == S_END) begin
          result_nxt = result_o;
        end
      end
      default: begin
        result_nxt = 64'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------
  // Datapath and registered outputs.
  // --------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 6'd0;
      work     <= 65'd0;
      sgn      <= 1'b0;
      dvd_neg  <= 1'b0;
      dvs_neg  <= 1'b0;
      dvs_mag  <= 32'd0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      if (load_ops) begin
        sgn     <= signed_div_i;
        dvd_neg <= opdata1_i[31];
        dvs_neg <= opdata2_i[31];
        dvs_mag <= dvs_abs;
        work    <= {33'd0, dvd_abs};
        cnt     <= 6'd0;
      end else if (step) begin
        work <= work_step;
        cnt  <= cnt + 6'd1;
      end
      result_o <= result_nxt;
      ready_o  <= ready_nxt;
    end
  end

  assign stall_o = start_i & ~ready_o;

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle 32-bit integer divider for the MIPS core's execute stage. It executes DIV and DIVU as a radix-2 restoring divider under a four-state controller, and produces {remainder, quotient} for the HI/LO registers. While a divide is in flight, it holds the pipeline through a stall request to the hazard unit. A branch-delay flush or exception can annul an operation in flight.

## Interface
- No parameters. Data width is fixed at 32.
- clk  in  1  — the only clock; all state changes on the rising edge.
- rst  in  1  — synchronous, active-high reset.
- signed_div_i  in  1  — 1 selects DIV (signed), 0 selects DIVU; sampled with start_i.
- opdata1_i  in  32  — dividend; sampled when a start is accepted.
- opdata2_i  in  32  — divisor; sampled when a start is accepted.
- start_i  in  1  — request from EX; must stay high until ready_o is seen.
- annul_i  in  1  — abort request (flush or exception).
- result_o  out  64  — {remainder[63:32] → HI, quotient[31:0] → LO}; nonzero only in END.
- ready_o  out  1  — high only in END.
- stall_o  out  1  — combinational, start_i & ~ready_o; drives the pipeline stall.

## Operation
States: FREE, BYZERO, ON, END.

- **Reset:** on rst, state ← FREE, cnt ← 0, result_o = 0, ready_o = 0. This applies from any state.
- **FREE:**
  - If start_i & ~annul_i and opdata2_i == 0: go to BYZERO.
  - If start_i & ~annul_i and opdata2_i != 0: go to ON. Latch signed_div_i, both operands' sign bits, and the operand magnitudes. Magnitudes are two's-complement absolute values when signed, raw values when unsigned. Also clear the 65-bit work register: upper 33 bits ← 0, lower 32 bits ← |dividend|. Set cnt ← 0.
  - Otherwise stay in FREE.
- **BYZERO:** next state is END with result 64'h0. Divide-by-zero is architecturally undefined; this design fixes it to zero.
- **ON:** one iteration per cycle.
  - Shift the work register left by 1.
  - Trial value = upper 33 bits − {1'b0, |divisor|}.
  - If the trial value is non-negative, upper ← trial and bit 0 ← 1; otherwise bit 0 ← 0.
  - cnt ← cnt + 1 (6-bit counter).
  - After the iteration with cnt == 31, go to END. Apply the sign fixup at that transition:
    - Quotient is negated if signed and the operand signs differ.
    - Remainder is negated if signed and the dividend was negative.
  - If annul_i == 1 or start_i == 0 in any ON cycle: go to FREE and discard the work.
- **END:** ready_o = 1 and result_o holds the final value.
  - Stay in END while start_i == 1. annul_i is ignored in END.
  - When start_i == 0: go to FREE, and result_o and ready_o return to 0.
- **Overflow case:** signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. This is plain 32-bit wrap, with no trap.
- **Back-to-back operations:** a new operation can only be accepted after one FREE cycle. EX therefore drops start_i for at least one cycle between divides.

## Timing
- **Normal divide:**
  - Start accepted at edge k.
  - Iterations happen at edges k+1 … k+32.
  - State is END after edge k+32, so ready_o is high from the cycle following edge k+32.
  - stall_o is high for 33 cycles, counting the start cycle.
- **Divide by zero:**
  - Accepted at edge k, BYZERO after edge k, END after edge k+1.
  - ready_o is high 2 cycles after start.
- **Annul:** if annul_i is high in an ON cycle, the state is FREE after that edge. ready_o never rises for the annulled operation.
- **Annul and start together in FREE:** annul wins; no operation starts.
- **Operand changes:** changes to opdata*_i or signed_div_i after acceptance have no effect.
- **Output registration:** result_o and ready_o are registered (state-decoded). stall_o is the only combinational output.

## Test plan
- **Unsigned divide:** DIVU 100 / 7, start_i held high → ready_o rises exactly 33 cycles after the start cycle; result_o = {32'd2, 32'd14}; with start_i dropped, ready_o = 0 and result_o = 0 the next cycle.
- **Signed divide:** DIV −7 / 2 (0xFFFFFFF9 / 0x2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also run DIV 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- **Divide by zero and overflow:**
  - DIVU 5 / 0 → ready_o high 2 cycles after start, result_o = 0.
  - DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- **Annul:** assert annul_i for one cycle at iteration 10 → FREE on the next cycle; ready_o never rises. A fresh DIVU 9 / 3 started afterwards returns {0, 3}.
- **Reset and start drop:**
  - rst pulsed at iteration 20 → FREE, all outputs 0 on the next cycle.
  - start_i dropped at iteration 5 → FREE, and no result.
- **Handshake hold:** keep start_i high for 4 cycles in END → ready_o and result_o stay stable for all 4 cycles and stall_o = 0. Run a randomized signed/unsigned sweep of 1000 operand pairs against a reference model.
